// File: rtl/key_event_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : key_event_scheduler_pkg                                         |
// | Brief  : Key codes, held-bitmap indices and event types for the scheduler |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package key_event_scheduler_pkg;

  localparam int c_key_w = 8;

  localparam logic [c_key_w-1:0] c_key_up    = 8'h75;
  localparam logic [c_key_w-1:0] c_key_down  = 8'h72;
  localparam logic [c_key_w-1:0] c_key_left  = 8'h6B;
  localparam logic [c_key_w-1:0] c_key_right = 8'h74;
  localparam logic [c_key_w-1:0] c_key_space = 8'h29;
  localparam logic [c_key_w-1:0] c_no_key    = 8'h00;

  localparam int c_held_up    = 0;
  localparam int c_held_down  = 1;
  localparam int c_held_left  = 2;
  localparam int c_held_right = 3;
  localparam int c_held_space = 4;

  localparam int c_key_ev_w = c_key_w + 2;

  typedef struct packed {
    logic [c_key_w-1:0] key;
    logic               press;
    logic               rpt;
  } key_ev_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic logic [4:0] held_mask(input logic [c_key_w-1:0] k);
    held_mask = 5'b0;
    case (k)
      c_key_up:    held_mask[c_held_up]    = 1'b1;
      c_key_down:  held_mask[c_held_down]  = 1'b1;
      c_key_left:  held_mask[c_held_left]  = 1'b1;
      c_key_right: held_mask[c_held_right] = 1'b1;
      c_key_space: held_mask[c_held_space] = 1'b1;
      default:     held_mask = 5'b0;
    endcase
  endfunction

  // Only the flap keys auto-repeat.
  function automatic logic is_repeatable(input logic [c_key_w-1:0] k);
    is_repeatable = (k == c_key_space) || (k == c_key_up);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_scheduler_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : key_event_fifo                                                  |
// | Brief  : Synchronous FIFO for key events, async active-low reset         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = push & (~full | w_pop_ok);
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/key_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : key_event_scheduler                                             |
// | Brief  : Turns keyboard code changes into queued press/release/repeat    |
// |          events with held bitmap and flap-key auto-repeat                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module key_event_scheduler
  import key_event_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [c_key_w-1:0] key,
  input  logic               key_state,
  input  logic               enable,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [c_key_w-1:0] ev_key,
  output logic               ev_press,
  output logic               ev_repeat,
  output logic [4:0]         held,
  output logic               overflow
);

  localparam int c_cnt_w = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [c_key_w-1:0] r_key_q;
  logic               r_state_q;
  logic               r_kb_ev;
  logic [c_key_w-1:0] r_kb_key;
  logic               r_kb_press;
  logic [4:0]         r_held;
  rpt_state_t         r_state;
  rpt_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_key_w-1:0] r_rpt_key;
  logic [c_key_w-1:0] w_rpt_key_nxt;
  logic               r_rpt_pend;
  logic               r_overflow;

  logic               w_kb_det;
  logic               w_kb_rpt_press;
  logic               w_kb_rpt_rel;
  logic               w_expire;
  logic               w_rpt_emit;
  logic               w_rpt_req;
  logic               w_push;
  key_ev_t            w_push_ev;
  logic [c_key_ev_w-1:0] w_head;
  key_ev_t            w_head_ev;
  logic               w_full;
  logic               w_empty;

  // Change detector: the code is registered here and the event pushed one edge later.
  assign w_kb_det = ({key, key_state} != {r_key_q, r_state_q}) && (key != c_no_key);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_key_q    <= c_no_key;
      r_state_q  <= 1'b0;
      r_kb_ev    <= 1'b0;
      r_kb_key   <= c_no_key;
      r_kb_press <= 1'b0;
    end else begin
      r_key_q    <= key;
      r_state_q  <= key_state;
      r_kb_ev    <= w_kb_det;
      r_kb_key   <= key;
      r_kb_press <= key_state;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_held <= 5'b0;
    end else if (r_kb_ev) begin
      r_held <= r_kb_press ? (r_held | held_mask(r_kb_key)) : (r_held & ~held_mask(r_kb_key));
    end
  end

  assign w_kb_rpt_press = r_kb_ev & r_kb_press & is_repeatable(r_kb_key);
  assign w_kb_rpt_rel   = r_kb_ev & ~r_kb_press & (r_kb_key == r_rpt_key);
  assign w_expire = ((r_state == RPT_DELAY)  && (r_cnt == c_cnt_w'(REPEAT_DELAY - 1))) ||
                    ((r_state == RPT_REPEAT) && (r_cnt == c_cnt_w'(REPEAT_PERIOD - 1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RPT_IDLE;
      r_cnt     <= '0;
      r_rpt_key <= c_no_key;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rpt_key <= w_rpt_key_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + c_cnt_w'(1);
    w_rpt_key_nxt = r_rpt_key;
    w_rpt_emit    = 1'b0;
    if (!enable) begin
      w_state_nxt = RPT_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        RPT_IDLE: begin
          w_cnt_nxt = '0;
          if (w_kb_rpt_press) begin
            w_state_nxt   = RPT_DELAY;
            w_rpt_key_nxt = r_kb_key;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (w_kb_rpt_rel) begin
            w_state_nxt = RPT_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_kb_rpt_press) begin
            w_state_nxt   = RPT_DELAY;
            w_cnt_nxt     = '0;
            w_rpt_key_nxt = r_kb_key;
          end else if (w_expire) begin
            w_state_nxt = RPT_REPEAT;
            w_cnt_nxt   = '0;
            w_rpt_emit  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = RPT_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Keyboard events win the push slot; a colliding repeat waits one entry deep.
  assign w_rpt_req = r_rpt_pend | w_rpt_emit;
  assign w_push    = enable & (r_kb_ev | w_rpt_req);

  always_comb begin
    w_push_ev = '0;
    if (r_kb_ev) begin
      w_push_ev.key   = r_kb_key;
      w_push_ev.press = r_kb_press;
      w_push_ev.rpt   = 1'b0;
    end else begin
      w_push_ev.key   = r_rpt_key;
      w_push_ev.press = 1'b1;
      w_push_ev.rpt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rpt_pend <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (!enable)      r_rpt_pend <= 1'b0;
      else if (r_kb_ev) r_rpt_pend <= w_rpt_req;
      else              r_rpt_pend <= r_rpt_pend & w_rpt_emit;
      r_overflow <= w_push & w_full & ~ev_ready;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_key_ev_w)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_push),
    .push_data (w_push_ev),
    .pop       (ev_ready),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_head_ev = w_head;
  assign ev_valid  = ~w_empty;
  assign ev_key    = ev_valid ? w_head_ev.key   : c_no_key;
  assign ev_press  = ev_valid & w_head_ev.press;
  assign ev_repeat = ev_valid & w_head_ev.rpt;
  assign held      = r_held;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
